fifo_feed_split: RTL and testbench

- Width down-converter that sits directly upstream of the single-clock sync FIFO.
- Accepts one wide word of RATIO×WID bits, plus a word count, over a valid/ready handshake.
- Pushes the valid WID-bit sub-words into the FIFO write port (validin/datain/full), least-significant sub-word first.
- It never writes into a full FIFO, so the FIFO overflow flag must stay low in normal operation.

---
 rtl/fifo_feed_split.sv | 95 +++++++++
 tb/tb_fifo_feed_split.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_feed_split.sv
// rtl/fifo_feed_split.sv - wide-word to FIFO sub-word down-converter
// Splits RATIO*WID input words into WID-bit FIFO pushes, low sub-word first.
module fifo_feed_split #(
   parameter int WID   = 32,
   parameter int RATIO = 4,
   parameter int NWID  = $clog2(RATIO + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 softreset,
   input  logic                 in_valid,
   input  logic [WID*RATIO-1:0] in_data,
   input  logic [NWID-1:0]      in_nwords,
   output logic                 in_ready,
   output logic                 fifo_validin,
   output logic [WID-1:0]       fifo_datain,
   input  logic                 fifo_full,
   output logic                 busy,
   output logic                 bad_len,
   output logic [31:0]          words_pushed
);

   typedef enum logic {S_IDLE, S_SPLIT} state_t;

   localparam logic [NWID-1:0] L_RATIO = NWID'(RATIO);
   localparam logic [NWID-1:0] L_ONE   = NWID'(1);

   state_t               r_state;
   logic [WID*RATIO-1:0] r_shreg;
   logic [NWID-1:0]      r_rem;
   logic                 r_busy;
   logic                 r_bad_len;
   logic [31:0]          r_words_pushed;

   logic                 w_push;
   logic                 w_accept;
   logic                 w_len_err;
   logic [NWID-1:0]      w_nclamp;

   assign w_push    = (r_state == S_SPLIT) && !fifo_full && !softreset;
   // Ready in SPLIT only on the final push, so the next word loads with no bubble.
   assign in_ready  = !rst && !softreset &&
                      ((r_state == S_IDLE) || (w_push && (r_rem == L_ONE)));
   assign w_accept  = in_valid && in_ready;
   assign w_len_err = (in_nwords == '0) || (in_nwords > L_RATIO);
   assign w_nclamp  = (in_nwords > L_RATIO) ? L_RATIO : in_nwords;

   assign fifo_validin = w_push;
   assign fifo_datain  = r_shreg[WID-1:0];
   assign busy         = r_busy;
   assign bad_len      = r_bad_len;
   assign words_pushed = r_words_pushed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_shreg        <= '0;
         r_rem          <= '0;
         r_busy         <= 1'b0;
         r_bad_len      <= 1'b0;
         r_words_pushed <= '0;
      end else if (softreset) begin
         r_state        <= S_IDLE;
         r_shreg        <= '0;
         r_rem          <= '0;
         r_busy         <= 1'b0;
         r_bad_len      <= 1'b0;
         r_words_pushed <= '0;
      end else begin
         r_bad_len <= w_accept && w_len_err;
         if (w_push)
            r_words_pushed <= r_words_pushed + 32'd1;
         // A reload on the last push overrides the shift of the old word.
         if (w_accept) begin
            r_shreg <= in_data;
            r_rem   <= w_nclamp;
            if (w_nclamp != '0) begin
               r_state <= S_SPLIT;
               r_busy  <= 1'b1;
            end else begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         end else if (w_push) begin
            r_shreg <= r_shreg >> WID;
            r_rem   <= r_rem - L_ONE;
            if (r_rem == L_ONE) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_feed_split.sv
// tb/tb_fifo_feed_split.sv - directed self-checking bench for fifo_feed_split
module tb_fifo_feed_split;
   localparam int WID   = 8;
   localparam int RATIO = 4;
   localparam int NWID  = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 softreset;
   logic                 in_valid;
   logic [WID*RATIO-1:0] in_data;
   logic [NWID-1:0]      in_nwords;
   logic                 in_ready;
   logic                 fifo_validin;
   logic [WID-1:0]       fifo_datain;
   logic                 fifo_full;
   logic                 busy;
   logic                 bad_len;
   logic [31:0]          words_pushed;

   logic force_full;
   logic use_model;
   logic ovf = 1'b0;
   int   pushes = 0;
   int   accepts = 0;
   int   base;
   int   acc0;
   int   p0;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] bx[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] bb[6]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
   logic       rdy[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // Model of a DEPTH=8 FIFO that is never read.
   assign fifo_full = use_model ? ((pushes - base) >= 8) : force_full;

   fifo_feed_split #(.WID(WID), .RATIO(RATIO), .NWID(NWID)) dut (
      .clk(clk), .rst(rst), .softreset(softreset),
      .in_valid(in_valid), .in_data(in_data), .in_nwords(in_nwords),
      .in_ready(in_ready), .fifo_validin(fifo_validin), .fifo_datain(fifo_datain),
      .fifo_full(fifo_full), .busy(busy), .bad_len(bad_len),
      .words_pushed(words_pushed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fifo_validin) begin
         pushes <= pushes + 1;
         if (fifo_full) ovf <= 1'b1;
      end
      if (in_valid && in_ready) accepts <= accepts + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; softreset = 1'b0; in_valid = 1'b0; in_data = '0; in_nwords = '0;
      force_full = 1'b0; use_model = 1'b0; base = 0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_validin", fifo_validin, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rel_ready", in_ready, 1);
      chk("rel_busy", busy, 0);
      chk("rel_badlen", bad_len, 0);
      chk("rel_words", words_pushed, 0);
      tick();

      // basic split
      in_valid = 1'b1; in_data = 32'h44332211; in_nwords = 3'd4;
      #1 chk("b_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("b_validin", fifo_validin, 1);
         chk("b_data", fifo_datain, bx[i]);
         chk("b_busy", busy, 1);
         tick();
      end
      #1;
      chk("b_idle", busy, 0);
      chk("b_novalid", fifo_validin, 0);
      chk("b_words", words_pushed, 4);

      // back-to-back words
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_nwords = 3'd4;
      tick();
      in_data = 32'h00002211; in_nwords = 3'd2;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("bb_validin", fifo_validin, 1);
         chk("bb_data", fifo_datain, bb[i]);
         if (i < 5) chk("bb_ready", in_ready, rdy[i]);
         tick();
         if (i == 3) in_valid = 1'b0;
      end
      #1;
      chk("bb_idle", busy, 0);
      chk("bb_words", words_pushed, 10);

      // backpressure
      in_valid = 1'b1; in_data = 32'h44332211; in_nwords = 3'd4;
      tick();
      in_valid = 1'b0;
      #1 chk("bp_d0", fifo_datain, 8'h11);
      tick();
      force_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_hold_valid", fifo_validin, 0);
         chk("bp_hold_data", fifo_datain, 8'h22);
         chk("bp_hold_ready", in_ready, 0);
         tick();
      end
      force_full = 1'b0;
      for (int i = 1; i < 4; i++) begin
         #1;
         chk("bp_validin", fifo_validin, 1);
         chk("bp_data", fifo_datain, bx[i]);
         tick();
      end
      #1;
      chk("bp_words", words_pushed, 14);
      chk("bp_busy", busy, 0);

      // zero-length word
      in_valid = 1'b1; in_data = 32'h00000055; in_nwords = 3'd0;
      #1 chk("z_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("z_badlen", bad_len, 1);
      chk("z_busy", busy, 0);
      chk("z_validin", fifo_validin, 0);
      tick();
      #1;
      chk("z_badlen_off", bad_len, 0);
      chk("z_words", words_pushed, 14);

      // over-length word is clamped
      in_valid = 1'b1; in_data = 32'h44332211; in_nwords = 3'd7;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (i == 0) chk("c_badlen", bad_len, 1);
         if (i == 1) chk("c_badlen_off", bad_len, 0);
         chk("c_validin", fifo_validin, 1);
         chk("c_data", fifo_datain, bx[i]);
         tick();
      end
      #1;
      chk("c_words", words_pushed, 18);
      chk("c_busy", busy, 0);

      // softreset mid-split
      in_valid = 1'b1; in_data = 32'h44332211; in_nwords = 3'd4;
      tick();
      in_valid = 1'b0;
      #1 chk("sr_d0", fifo_datain, 8'h11);
      tick();
      #1 chk("sr_d1", fifo_datain, 8'h22);
      tick();
      softreset = 1'b1;
      p0 = pushes;
      #1;
      chk("sr_ready", in_ready, 0);
      chk("sr_validin", fifo_validin, 0);
      tick();
      softreset = 1'b0;
      #1;
      chk("sr_busy", busy, 0);
      chk("sr_words", words_pushed, 0);
      chk("sr_ready_after", in_ready, 1);
      tick();
      #1;
      chk("sr_validin_after", fifo_validin, 0);
      chk("sr_nopush", pushes, p0);

      // async reset mid-split
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1 chk("ar_d0", fifo_datain, 8'h11);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_validin", fifo_validin, 0);
      chk("ar_words", words_pushed, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // fill a DEPTH=8 FIFO that is never drained
      base = pushes; acc0 = accepts; use_model = 1'b1;
      in_valid = 1'b1; in_data = 32'h44332211; in_nwords = 3'd4;
      repeat (15) tick();
      #1;
      chk("f_pushes", pushes - base, 8);
      chk("f_accepts", accepts - acc0, 3);
      chk("f_busy", busy, 1);
      chk("f_rem", dut.r_rem, 4);
      chk("f_ready", in_ready, 0);
      chk("f_validin", fifo_validin, 0);
      chk("f_data", fifo_datain, 8'h11);
      chk("f_ovf", ovf, 0);
      in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
